eng_load_sched: RTL and testbench
=================================

# eng_load_sched

Sequencing controller between the clause-node source and the solver `top`. It streams clause nodes into each of `NUM_ENGINE` lookup engines in order and delivers each engine's dummy pointer. It steps the engine select with `change_eng` and releases `halt` once every engine is loaded. It then watches for conflict or solve completion and re-halts the array, so the bench no longer hand-drives these signals.

## Interface
Parameters:
- `NUM_ENGINE`, 4: number of engines loaded; engine index width `EW = $clog2(NUM_ENGINE)` (min 1).
- `NODE_W`, 64: width of `node_t`.
- `PTR_W`, 16: width of `ptr_t`.
- `MAX_NODES`, 256: maximum nodes accepted per engine; node counter is `$clog2(MAX_NODES+1)` bits.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a load sequence; honoured only in IDLE.
- `abort`, in, 1: return to IDLE from any state.
- `src_node`, in, NODE_W: node from the source stream.
- `src_valid`, in, 1: source beat valid.
- `src_last`, in, 1: beat is the final node of the current engine.
- `src_dummy_ptr`, in, PTR_W: dummy pointer of the current engine; sampled with the `src_last` beat.
- `src_ready`, out, 1: controller accepts a beat.
- `node_in`, out, NODE_W: node to `top`.
- `node_in_valid`, out, 1: `node_in` valid for one cycle.
- `dummy_ptr`, out, PTR_W: pointer to `top`.
- `dummy_ptr_valid`, out, 1: one-cycle pointer strobe.
- `change_eng`, out, 1: one-cycle pulse that advances `top`'s engine select.
- `halt`, out, 1: engines frozen.
- `conflict`, in, 1: conflict reported by `top`.
- `sat_done`, in, 1: solve finished without conflict.
- `eng_idx`, out, EW: engine currently being loaded.
- `busy`, out, 1: state is not IDLE.
- `done`, out, 1: sticky; run ended by `sat_done`.
- `conflict_seen`, out, 1: sticky; run ended by `conflict`.
- `load_err`, out, 1: sticky; per-engine node overflow.

## Operation
- States: IDLE, LOAD, DPTR, SWITCH, RUN, HALTED.
- `src_ready` is combinational and equals `(state==LOAD)`. All other outputs are registered.
- **IDLE**
  - `halt` = 1.
  - On `start`: go to LOAD, clear `eng_idx`, the node counter and the sticky flags.
- **LOAD**
  - Each accepted beat (`src_valid && src_ready`) registers `node_in <= src_node` with `node_in_valid` = 1 for one cycle, and increments the node counter.
  - An accepted beat with `src_last`: latch `src_dummy_ptr` and go to DPTR.
  - A beat that would be node `MAX_NODES+1` for the current engine: the beat is dropped (no `node_in_valid`), `load_err` is set, state goes to HALTED.
- **DPTR**
  - Drive `dummy_ptr`, with `dummy_ptr_valid` = 1 for one cycle; go to SWITCH.
- **SWITCH**
  - If `eng_idx == NUM_ENGINE-1`: go to RUN.
  - Otherwise: pulse `change_eng`, increment `eng_idx`, clear the node counter, return to LOAD.
- **RUN**
  - `halt` = 0.
  - `conflict`: set `conflict_seen`, go to HALTED.
  - Else `sat_done`: set `done`, go to HALTED.
- **HALTED**
  - `halt` = 1; hold all flags until `start` (behaves as IDLE) or `abort`.
- **Priority and ignored inputs**
  - `abort` beats `start`.
  - `conflict` beats `sat_done`.
  - `start` is ignored outside IDLE and HALTED.
  - `conflict` and `sat_done` are ignored outside RUN.
- **`abort`**
  - Next state is IDLE.
  - Next cycle: `halt` = 1; `node_in_valid`, `dummy_ptr_valid` and `change_eng` are 0.
  - Sticky flags are unchanged.

## Timing
- Reset values:
  - `halt` = 1, `busy` = 0.
  - `src_ready` = 0.
  - `node_in_valid` = 0, `dummy_ptr_valid` = 0, `change_eng` = 0.
  - `node_in` = 0, `dummy_ptr` = 0, `eng_idx` = 0.
  - `done` = 0, `conflict_seen` = 0, `load_err` = 0.
  - State = IDLE.
- Reset asserted mid-sequence forces all of the above immediately, without waiting for `clk`.
- `start` sampled at cycle s: `src_ready` = 1 at s+1.
- Beat accepted at cycle t: `node_in_valid` at t+1. Back-to-back beats give one node per cycle.
- `src_last` accepted at cycle t:
  - t+1: `node_in_valid` for the last node, state DPTR, `src_ready` = 0.
  - t+2: `dummy_ptr_valid`.
  - t+3: either `change_eng` pulse (not the last engine) or `halt` = 0 (last engine).
  - t+3: `src_ready` = 1 again when more engines remain.
- `conflict` sampled at r while in RUN: `halt` = 1 and `conflict_seen` = 1 at r+1.
- Never asserted in the same cycle: `node_in_valid`, `dummy_ptr_valid` and `change_eng`.

## Test plan
- `NUM_ENGINE` = 2, 3 nodes then 2 nodes, ptrs 0x10 and 0x20:
  - 5 `node_in_valid` pulses in source order, ptr 0x10 then 0x20, exactly 1 `change_eng`.
  - `halt` falls 3 cycles after the second `src_last`; `eng_idx` ends at 1.
- `src_valid` toggled every other cycle during LOAD: nodes forwarded in order, none duplicated or lost.
- RUN with `conflict` and `sat_done` asserted in the same cycle: `halt` = 1 next cycle, `conflict_seen` = 1, `done` = 0.
- `MAX_NODES` = 4, 5 beats to engine 0: 4 `node_in_valid` pulses, `load_err` = 1, state HALTED, no `dummy_ptr_valid`.
- `abort` in DPTR, then `start`: no `dummy_ptr_valid` from the aborted run; the new load begins at `eng_idx` 0 with `src_ready` high 1 cycle after `start`.
- `rst_n` asserted in RUN: `halt` = 1 asynchronously and all outputs at their reset values.

Source files
------------

// File: rtl/eng_load_sched.sv
// rtl/eng_load_sched.sv - streams clause nodes into each lookup engine, then runs and re-halts the array
module eng_load_sched #(
  parameter int NUM_ENGINE = 4,
  parameter int NODE_W     = 64,
  parameter int PTR_W      = 16,
  parameter int MAX_NODES  = 256,
  parameter int EW         = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NODE_W-1:0] src_node,
  input  logic              src_valid,
  input  logic              src_last,
  input  logic [PTR_W-1:0]  src_dummy_ptr,
  output logic              src_ready,
  output logic [NODE_W-1:0] node_in,
  output logic              node_in_valid,
  output logic [PTR_W-1:0]  dummy_ptr,
  output logic              dummy_ptr_valid,
  output logic              change_eng,
  output logic              halt,
  input  logic              conflict,
  input  logic              sat_done,
  output logic [EW-1:0]     eng_idx,
  output logic              busy,
  output logic              done,
  output logic              conflict_seen,
  output logic              load_err
);

  localparam int CW = $clog2(MAX_NODES + 1);
  localparam logic [CW-1:0] NODE_LIMIT = CW'(MAX_NODES);
  localparam logic [EW-1:0] LAST_ENG   = EW'(NUM_ENGINE - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DPTR, SWITCH, RUN, HALTED} state_t;

  state_t            state;
  logic [CW-1:0]     node_cnt;
  logic [PTR_W-1:0]  ptr_q;

  assign src_ready = (state == LOAD);

  // rst_n is an active-high asynchronous reset despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state           <= IDLE;
      node_cnt        <= '0;
      ptr_q           <= '0;
      node_in         <= '0;
      node_in_valid   <= 1'b0;
      dummy_ptr       <= '0;
      dummy_ptr_valid <= 1'b0;
      change_eng      <= 1'b0;
      halt            <= 1'b1;
      eng_idx         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      conflict_seen   <= 1'b0;
      load_err        <= 1'b0;
    end else begin
      node_in_valid   <= 1'b0;
      dummy_ptr_valid <= 1'b0;
      change_eng      <= 1'b0;
      if (abort) begin
        state <= IDLE;
        halt  <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, HALTED: begin
            if (start) begin
              state         <= LOAD;
              busy          <= 1'b1;
              halt          <= 1'b1;
              eng_idx       <= '0;
              node_cnt      <= '0;
              done          <= 1'b0;
              conflict_seen <= 1'b0;
              load_err      <= 1'b0;
            end
          end
          LOAD: begin
            if (src_valid) begin
              // the beat beyond the per-engine limit is dropped and freezes the array
              if (node_cnt == NODE_LIMIT) begin
                load_err <= 1'b1;
                state    <= HALTED;
              end else begin
                node_in       <= src_node;
                node_in_valid <= 1'b1;
                node_cnt      <= node_cnt + 1'b1;
                if (src_last) begin
                  ptr_q <= src_dummy_ptr;
                  state <= DPTR;
                end
              end
            end
          end
          DPTR: begin
            dummy_ptr       <= ptr_q;
            dummy_ptr_valid <= 1'b1;
            state           <= SWITCH;
          end
          SWITCH: begin
            if (eng_idx == LAST_ENG) begin
              halt  <= 1'b0;
              state <= RUN;
            end else begin
              change_eng <= 1'b1;
              eng_idx    <= eng_idx + 1'b1;
              node_cnt   <= '0;
              state      <= LOAD;
            end
          end
          RUN: begin
            if (conflict) begin
              conflict_seen <= 1'b1;
              halt          <= 1'b1;
              state         <= HALTED;
            end else if (sat_done) begin
              done  <= 1'b1;
              halt  <= 1'b1;
              state <= HALTED;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eng_load_sched.sv
// tb/tb_eng_load_sched.sv - directed self-checking bench for eng_load_sched
module tb_eng_load_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [63:0] src_node = '0;
  logic        src_valid = 1'b0, src_last = 1'b0;
  logic [15:0] src_dummy_ptr = '0;
  logic        src_ready;
  logic [63:0] node_in;
  logic        node_in_valid;
  logic [15:0] dummy_ptr;
  logic        dummy_ptr_valid, change_eng, halt;
  logic        conflict = 1'b0, sat_done = 1'b0;
  logic [0:0]  eng_idx;
  logic        busy, done, conflict_seen, load_err;

  int checks = 0;
  int failures = 0;
  int ce_cnt = 0;
  int excl_err = 0;
  logic [63:0] node_q[$];
  logic [15:0] ptr_q[$];
  logic [63:0] exp_nodes[5];

  eng_load_sched #(.NUM_ENGINE(2), .NODE_W(64), .PTR_W(16), .MAX_NODES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_node(src_node), .src_valid(src_valid), .src_last(src_last),
    .src_dummy_ptr(src_dummy_ptr), .src_ready(src_ready),
    .node_in(node_in), .node_in_valid(node_in_valid),
    .dummy_ptr(dummy_ptr), .dummy_ptr_valid(dummy_ptr_valid),
    .change_eng(change_eng), .halt(halt), .conflict(conflict), .sat_done(sat_done),
    .eng_idx(eng_idx), .busy(busy), .done(done),
    .conflict_seen(conflict_seen), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (node_in_valid) node_q.push_back(node_in);
      if (dummy_ptr_valid) ptr_q.push_back(dummy_ptr);
      if (change_eng) ce_cnt++;
      if (int'(node_in_valid) + int'(dummy_ptr_valid) + int'(change_eng) > 1) excl_err++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat_last(input logic [63:0] n, input logic [15:0] p);
    src_valid = 1'b1; src_node = n; src_last = 1'b1; src_dummy_ptr = p;
    tick();
    src_valid = 1'b0; src_last = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_halt", halt, 1); chk("rst_busy", busy, 0); chk("rst_ready", src_ready, 0);
    chk("rst_niv", node_in_valid, 0); chk("rst_node", node_in, 0);
    chk("rst_ptr", dummy_ptr, 0); chk("rst_idx", eng_idx, 0);
    chk("rst_flags", {done, conflict_seen, load_err}, 0);
    rst_n = 1'b0;
    tick();

    // two engines: 3 nodes then 2 nodes with a gapped source
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ready", src_ready, 1); chk("start_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      src_valid = 1'b1; src_node = 64'hA0 + 64'(i); src_last = (i == 2); src_dummy_ptr = 16'h10;
      tick();
    end
    src_valid = 1'b0; src_last = 1'b0;
    chk("e0_t1_niv", node_in_valid, 1); chk("e0_t1_node", node_in, 64'hA2); chk("e0_t1_ready", src_ready, 0);
    tick();
    chk("e0_t2_dpv", dummy_ptr_valid, 1); chk("e0_t2_ptr", dummy_ptr, 16'h10);
    tick();
    chk("e0_t3_ce", change_eng, 1); chk("e0_t3_ready", src_ready, 1); chk("e0_t3_idx", eng_idx, 1);
    src_valid = 1'b1; src_node = 64'hB0; src_last = 1'b0; tick();
    src_valid = 1'b0; tick();
    src_valid = 1'b1; src_node = 64'hB1; src_last = 1'b1; src_dummy_ptr = 16'h20; tick();
    src_valid = 1'b0; src_last = 1'b0;
    chk("e1_t1_halt", halt, 1);
    tick();
    chk("e1_t2_halt", halt, 1); chk("e1_t2_ptr", dummy_ptr, 16'h20);
    tick();
    chk("e1_t3_halt", halt, 0); chk("e1_t3_idx", eng_idx, 1); chk("e1_t3_ce", change_eng, 0);
    exp_nodes = '{64'hA0, 64'hA1, 64'hA2, 64'hB0, 64'hB1};
    chk("node_count", node_q.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("node_order%0d", i), (i < node_q.size()) ? node_q[i] : 64'hX, exp_nodes[i]);
    chk("ptr_count", ptr_q.size(), 2);
    chk("ptr0", (ptr_q.size() > 0) ? ptr_q[0] : 16'hX, 16'h10);
    chk("ptr1", (ptr_q.size() > 1) ? ptr_q[1] : 16'hX, 16'h20);
    chk("ce_count", ce_cnt, 1);

    // conflict and sat_done together: conflict wins
    conflict = 1'b1; sat_done = 1'b1; tick(); conflict = 1'b0; sat_done = 1'b0;
    chk("cf_halt", halt, 1); chk("cf_seen", conflict_seen, 1); chk("cf_done", done, 0); chk("cf_busy", busy, 1);

    // overflow: five beats into a four-node engine
    node_q.delete(); ptr_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    chk("ov_clear_cf", conflict_seen, 0); chk("ov_ready", src_ready, 1);
    for (int i = 0; i < 5; i++) begin
      src_valid = 1'b1; src_node = 64'hC0 + 64'(i); src_last = 1'b0;
      tick();
    end
    src_valid = 1'b0;
    chk("ov_err", load_err, 1); chk("ov_ready_off", src_ready, 0);
    chk("ov_niv", node_in_valid, 0); chk("ov_node", node_in, 64'hC3);
    tick(); tick();
    chk("ov_nodes", node_q.size(), 4); chk("ov_no_ptr", ptr_q.size(), 0);
    chk("ov_halt", halt, 1); chk("ov_busy", busy, 1);

    // abort in engine 1's DPTR, then restart
    ptr_q.delete(); ce_cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk("ab_clear_err", load_err, 0);
    beat_last(64'hE0, 16'h30);
    chk("ab_idx1", eng_idx, 1);
    src_valid = 1'b1; src_node = 64'hE1; src_last = 1'b1; src_dummy_ptr = 16'h40; tick();
    src_valid = 1'b0; src_last = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_busy", busy, 0); chk("ab_halt", halt, 1);
    chk("ab_dpv", dummy_ptr_valid, 0); chk("ab_ready", src_ready, 0);
    tick(); tick();
    chk("ab_ptr_count", ptr_q.size(), 1);
    chk("ab_ptr0", (ptr_q.size() > 0) ? ptr_q[0] : 16'hX, 16'h30);
    chk("ab_ce", ce_cnt, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("rs_ready", src_ready, 1); chk("rs_idx", eng_idx, 0);

    // complete run ending in sat_done
    beat_last(64'hF0, 16'h50);
    beat_last(64'hF1, 16'h60);
    chk("sd_run_halt", halt, 0);
    sat_done = 1'b1; tick(); sat_done = 1'b0;
    chk("sd_done", done, 1); chk("sd_cf", conflict_seen, 0); chk("sd_halt", halt, 1);

    // asynchronous reset while running
    start = 1'b1; tick(); start = 1'b0;
    chk("r2_done_clr", done, 0);
    beat_last(64'h11, 16'h70);
    beat_last(64'h12, 16'h80);
    chk("r2_run_halt", halt, 0);
    #2 rst_n = 1'b1;
    #1;
    chk("ar_halt", halt, 1); chk("ar_busy", busy, 0); chk("ar_ready", src_ready, 0);
    chk("ar_idx", eng_idx, 0); chk("ar_node", node_in, 0); chk("ar_ptr", dummy_ptr, 0);
    chk("ar_strobes", {node_in_valid, dummy_ptr_valid, change_eng}, 0);
    chk("ar_flags", {done, conflict_seen, load_err}, 0);
    chk("exclusive_strobes", excl_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
